multi_tick_generator: RTL and testbench
=======================================

Name: multi_tick_generator

Overview:
- NUM_CH independent, run-time programmable tick generators sharing one clock and one global enable.
- Each channel emits single-cycle strobes at a programmable period, in either periodic or one-shot mode.
- Replaces fixed-count single heartbeats. Feeds display multiplexers, debouncers, UART baud strobes and LED blink logic from one configurable block.

Parameters:
- NUM_CH, 4, number of independent channels (1..16).
- MAX_PERIOD, 50_000_000, largest programmable period in clk cycles; CNT_W = $clog2(MAX_PERIOD+1).
- DEFAULT_PERIOD, 50_000_000, period loaded into every channel at reset (must be <= MAX_PERIOD).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high; clock clk
- enable  in  1  global count enable; when low all counters hold and no ticks issue
- ch_en  in  NUM_CH  per-channel count enable, ANDed with enable
- cfg_we  in  1  write strobe for period/mode of channel cfg_ch
- cfg_start  in  1  (re)arm strobe for channel cfg_ch
- cfg_ch  in  $clog2(NUM_CH) (min 1)  target channel index
- cfg_period  in  CNT_W  new period
- cfg_mode  in  1  0 = periodic, 1 = one-shot
- tick  out  NUM_CH  registered one-cycle strobes
- busy  out  NUM_CH  channel armed and counting

Behaviour:
- Reset values, every channel:
  - counter = 0, period = DEFAULT_PERIOD, mode = periodic.
  - busy = 1, tick = 0.
  - Reset dominates all other inputs.
- Advance condition per channel: adv = enable & ch_en[i] & busy[i] & (period != 0).
- On each clk edge with adv:
  - If counter == period-1: counter <= 0, tick[i] <= 1.
  - Else: counter <= counter+1, tick[i] <= 0.
- Without adv: counter holds, tick[i] <= 0.
- Tick is never asserted while enable is low.
- Latency: with adv continuously high from the first edge after reset release, tick[i] is high for the clock after the P-th edge. Ticks repeat every P cycles.
- P = 1: tick high every cycle while adv holds.
- P = 0: channel idles; tick stays 0, counter holds, busy unchanged.
- One-shot mode: the edge that issues tick also clears busy[i]. The channel then holds with counter = 0 until cfg_start.
- Periodic mode: busy stays 1 until reset.
- cfg_we targeting channel i, same edge:
  - period <= cfg_period, mode <= cfg_mode, counter <= 0, tick[i] <= 0.
  - The write overrides any advance or terminal count on that edge.
  - Other channels are unaffected.
- cfg_start targeting channel i: counter <= 0, busy[i] <= 1, tick[i] <= 0.
- cfg_we and cfg_start together on the same channel: both apply and the channel is armed with the new period/mode.
- cfg_period > MAX_PERIOD: saturates to MAX_PERIOD.
- cfg_ch >= NUM_CH: cfg_we and cfg_start are ignored.
- Counter width is CNT_W. Comparison uses period-1 computed in CNT_W bits; the period = 0 case is excluded by adv.

Optional Feature:
- Macro: TICK_PHASE_EN.
- With the macro:
  - Extra input cfg_phase (CNT_W).
  - On cfg_we or cfg_start, counter <= min(cfg_phase, period-1) instead of 0.
  - With period = 0, counter <= 0.
  - This lets channels with equal periods be staggered. The first tick arrives after period - phase advancing edges.
- Without the macro:
  - No cfg_phase port.
  - Counter always restarts at 0.

Decomposition:
- Shared package/header tick_gen_pkg holds:
  - MODE_PERIODIC = 1'b0 and MODE_ONESHOT = 1'b1.
  - The CNT_W derivation function used by both modules.
- Sub-module tick_channel, instantiated NUM_CH times via generate, contains:
  - period/mode/counter/busy/tick registers.
  - Decoded per-channel we/start/adv inputs.
- The top level holds only address decode, the enable AND, and the saturation of cfg_period.

Test Plan:
- Reset, then DEFAULT_PERIOD overridden by writing ch0 period = 4, periodic, enable = 1, ch_en = all ones -> tick[0] high for one cycle on edges 4, 8, 12 after the write; busy[0] = 1 throughout.
- ch1 one-shot, period 3 -> single tick on the 3rd edge, busy[1] falls on the same edge, no further ticks for 20 cycles; cfg_start on ch1 -> next tick 3 edges later.
- ch0 period 5, enable dropped for 7 cycles after 2 advances -> counter frozen, no ticks; after re-enable, tick after 3 more edges.
- cfg_we to ch2 with period 2 on the exact edge ch2 would tick (old period 6) -> no tick that edge; next ticks at 2 and 4 edges later.
- Write period 0 to ch3 -> tick[3] stays 0 for 50 cycles; cfg_ch = NUM_CH write -> no channel changes; cfg_period = MAX_PERIOD+5 -> reads back as MAX_PERIOD (period observed via tick spacing).
- Assert reset mid-count on all channels -> next edge: tick = 0, busy = all ones, periods = DEFAULT_PERIOD; with TICK_PHASE_EN, period 8 and phase 6 -> first tick after 2 edges, then every 8.

Source files
------------

// File: rtl/tick_gen_pkg.sv
// Shared definitions for the multi-channel tick generator: channel modes and width helpers.
package tick_gen_pkg;

    typedef enum logic {
        MODE_PERIODIC = 1'b0,
        MODE_ONESHOT  = 1'b1
    } mode_e;

    // Counter width able to hold every value 0..max_period.
    function automatic int unsigned cnt_width(input int unsigned max_period);
        return $clog2(max_period + 1);
    endfunction

    // Channel index width, never narrower than one bit.
    function automatic int unsigned idx_width(input int unsigned num_ch);
        return (num_ch > 1) ? $clog2(num_ch) : 1;
    endfunction

endpackage

// File: rtl/tick_channel.sv
// One programmable tick channel: period/mode/counter/busy state and strobe generation.
// Optional macro TICK_PHASE_EN adds a start-phase load value for the counter.
module tick_channel
    import tick_gen_pkg::*;
#(
    parameter int unsigned CNT_W          = 26,
    parameter int unsigned DEFAULT_PERIOD = 50_000_000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             we,
    input  logic             start,
    input  logic             adv_en,
    input  logic [CNT_W-1:0] cfg_period,
    input  logic             cfg_mode,
`ifdef TICK_PHASE_EN
    input  logic [CNT_W-1:0] cfg_phase,
`endif
    output logic             tick,
    output logic             busy
);

    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] period_nxt;
    logic [CNT_W-1:0] counter;
    logic [CNT_W-1:0] counter_nxt;
    logic [CNT_W-1:0] load_period;
    logic [CNT_W-1:0] load_val;
    logic [CNT_W-1:0] last;
    mode_e            mode;
    mode_e            mode_nxt;
    logic             busy_nxt;
    logic             tick_nxt;
    logic             adv;

    assign last = period - CNT_W'(1);
    assign adv  = adv_en & busy & (period != '0);

    // Counter value applied on a write or re-arm; a write uses the incoming period.
    always_comb begin
        load_period = we ? cfg_period : period;
        load_val    = '0;
`ifdef TICK_PHASE_EN
        if (load_period != '0) begin
            if (cfg_phase > load_period - CNT_W'(1)) begin
                load_val = load_period - CNT_W'(1);
            end else begin
                load_val = cfg_phase;
            end
        end
`else
        load_val = '0;
`endif
    end

    // Next-state: configuration access overrides any advance on the same edge.
    always_comb begin
        period_nxt  = period;
        mode_nxt    = mode;
        counter_nxt = counter;
        busy_nxt    = busy;
        tick_nxt    = 1'b0;
        if (we || start) begin
            if (we) begin
                period_nxt = cfg_period;
                mode_nxt   = mode_e'(cfg_mode);
            end
            if (start) begin
                busy_nxt = 1'b1;
            end
            counter_nxt = load_val;
        end else if (adv) begin
            if (counter == last) begin
                counter_nxt = '0;
                tick_nxt    = 1'b1;
                if (mode == MODE_ONESHOT) begin
                    busy_nxt = 1'b0;
                end
            end else begin
                counter_nxt = counter + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            period  <= CNT_W'(DEFAULT_PERIOD);
            mode    <= MODE_PERIODIC;
            counter <= '0;
            busy    <= 1'b1;
            tick    <= 1'b0;
        end else begin
            period  <= period_nxt;
            mode    <= mode_nxt;
            counter <= counter_nxt;
            busy    <= busy_nxt;
            tick    <= tick_nxt;
        end
    end

endmodule

// File: rtl/multi_tick_generator.sv
// NUM_CH independent programmable tick generators with shared enable and config port.
// Optional macro TICK_PHASE_EN adds the cfg_phase input for staggered channel starts.
module multi_tick_generator
    import tick_gen_pkg::*;
#(
    parameter  int unsigned NUM_CH         = 4,
    parameter  int unsigned MAX_PERIOD     = 50_000_000,
    parameter  int unsigned DEFAULT_PERIOD = 50_000_000,
    localparam int unsigned CNT_W          = cnt_width(MAX_PERIOD),
    localparam int unsigned CH_W           = idx_width(NUM_CH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic [NUM_CH-1:0] ch_en,
    input  logic              cfg_we,
    input  logic              cfg_start,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [CNT_W-1:0]  cfg_period,
    input  logic              cfg_mode,
`ifdef TICK_PHASE_EN
    input  logic [CNT_W-1:0]  cfg_phase,
`endif
    output logic [NUM_CH-1:0] tick,
    output logic [NUM_CH-1:0] busy
);

    localparam logic [CNT_W-1:0] MAX_P = CNT_W'(MAX_PERIOD);

    logic [CNT_W-1:0]  sat_period;
    logic [NUM_CH-1:0] we_dec;
    logic [NUM_CH-1:0] start_dec;
    logic [NUM_CH-1:0] adv_en;

    assign sat_period = (cfg_period > MAX_P) ? MAX_P : cfg_period;

    // Out-of-range indices match no channel, so those accesses are dropped.
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        assign we_dec[i]    = cfg_we    & (cfg_ch == CH_W'(i));
        assign start_dec[i] = cfg_start & (cfg_ch == CH_W'(i));
        assign adv_en[i]    = enable    & ch_en[i];

        tick_channel #(
            .CNT_W          (CNT_W),
            .DEFAULT_PERIOD (DEFAULT_PERIOD)
        ) u_channel (
            .clk        (clk),
            .reset      (reset),
            .we         (we_dec[i]),
            .start      (start_dec[i]),
            .adv_en     (adv_en[i]),
            .cfg_period (sat_period),
            .cfg_mode   (cfg_mode),
`ifdef TICK_PHASE_EN
            .cfg_phase  (cfg_phase),
`endif
            .tick       (tick[i]),
            .busy       (busy[i])
        );
    end

endmodule

// File: tb/tb_multi_tick_generator.sv
// Directed plus randomized bench for multi_tick_generator against a countdown reference model.
module tb_multi_tick_generator;

    localparam int unsigned NUM_CH  = 5;
    localparam int unsigned MAX_P   = 20;
    localparam int unsigned DEF_P   = 10;
    localparam int unsigned CNT_W   = 5;
    localparam int unsigned CH_W    = 3;

    logic              clk = 1'b0;
    logic              reset;
    logic              enable;
    logic [NUM_CH-1:0] ch_en;
    logic              cfg_we;
    logic              cfg_start;
    logic [CH_W-1:0]   cfg_ch;
    logic [CNT_W-1:0]  cfg_period;
    logic              cfg_mode;
    logic [CNT_W-1:0]  cfg_phase;
    logic [NUM_CH-1:0] tick;
    logic [NUM_CH-1:0] busy;

    int checks = 0;
    int errors = 0;

    // Reference model: edges remaining until the next tick for each channel.
    int                m_per   [NUM_CH];
    int                m_rem   [NUM_CH];
    bit                m_os    [NUM_CH];
    logic [NUM_CH-1:0] m_armed;
    logic [NUM_CH-1:0] m_tick;

    multi_tick_generator #(
        .NUM_CH         (NUM_CH),
        .MAX_PERIOD     (MAX_P),
        .DEFAULT_PERIOD (DEF_P)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .ch_en      (ch_en),
        .cfg_we     (cfg_we),
        .cfg_start  (cfg_start),
        .cfg_ch     (cfg_ch),
        .cfg_period (cfg_period),
        .cfg_mode   (cfg_mode),
`ifdef TICK_PHASE_EN
        .cfg_phase  (cfg_phase),
`endif
        .tick       (tick),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        int ph;
        bit hw;
        bit hs;
        for (int i = 0; i < NUM_CH; i++) begin
            if (reset) begin
                m_per[i]   = DEF_P;
                m_rem[i]   = DEF_P;
                m_os[i]    = 1'b0;
                m_armed[i] = 1'b1;
                m_tick[i]  = 1'b0;
            end else begin
                m_tick[i] = 1'b0;
                hw = cfg_we    && (int'(cfg_ch) == i);
                hs = cfg_start && (int'(cfg_ch) == i);
                if (hw || hs) begin
                    if (hw) begin
                        m_per[i] = (int'(cfg_period) > MAX_P) ? MAX_P : int'(cfg_period);
                        m_os[i]  = cfg_mode;
                    end
                    if (hs) m_armed[i] = 1'b1;
                    ph = 0;
`ifdef TICK_PHASE_EN
                    if (m_per[i] != 0)
                        ph = (int'(cfg_phase) < m_per[i] - 1) ? int'(cfg_phase) : m_per[i] - 1;
`endif
                    m_rem[i] = m_per[i] - ph;
                end else if (enable && ch_en[i] && m_armed[i] && m_per[i] != 0) begin
                    m_rem[i]--;
                    if (m_rem[i] == 0) begin
                        m_tick[i] = 1'b1;
                        m_rem[i]  = m_per[i];
                        if (m_os[i]) m_armed[i] = 1'b0;
                    end
                end
            end
        end
    endtask

    // One clock: advance model with the inputs seen at the edge, then compare.
    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        chk("tick_model", 32'(tick), 32'(m_tick));
        chk("busy_model", 32'(busy), 32'(m_armed));
    endtask

    task automatic cfg(input int ch, input int per, input bit mode, input bit we,
                       input bit st, input int phase);
        cfg_ch     = CH_W'(ch);
        cfg_period = CNT_W'(per);
        cfg_mode   = mode;
        cfg_we     = we;
        cfg_start  = st;
        cfg_phase  = CNT_W'(phase);
        step();
        cfg_we     = 1'b0;
        cfg_start  = 1'b0;
    endtask

    initial begin
        reset = 1'b1; enable = 1'b1; ch_en = '1;
        cfg_we = 1'b0; cfg_start = 1'b0; cfg_ch = '0;
        cfg_period = '0; cfg_mode = 1'b0; cfg_phase = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            m_per[i] = 0; m_rem[i] = 0; m_os[i] = 1'b0;
        end
        m_armed = '0; m_tick = '0;
        #2;
        step(); step();
        chk("reset_tick", 32'(tick), 32'd0);
        chk("reset_busy", 32'(busy), 32'h1f);
        reset = 1'b0;

        // ch0 periodic, period 4
        cfg(0, 4, 1'b0, 1'b1, 1'b0, 0);
        for (int k = 1; k <= 12; k++) begin
            step();
            chk("ch0_p4_tick", 32'(tick[0]), (k % 4 == 0) ? 32'd1 : 32'd0);
            chk("ch0_p4_busy", 32'(busy[0]), 32'd1);
        end

        // ch1 one-shot, period 3, then re-arm
        cfg(1, 3, 1'b1, 1'b1, 1'b0, 0);
        step(); step(); step();
        chk("ch1_os_tick", 32'(tick[1]), 32'd1);
        chk("ch1_os_busy", 32'(busy[1]), 32'd0);
        for (int k = 0; k < 20; k++) begin
            step();
            chk("ch1_os_quiet", 32'(tick[1]), 32'd0);
        end
        cfg(1, 0, 1'b0, 1'b0, 1'b1, 0);
        chk("ch1_rearm_busy", 32'(busy[1]), 32'd1);
        step(); step(); step();
        chk("ch1_rearm_tick", 32'(tick[1]), 32'd1);

        // ch0 period 5 with enable dropped mid-count
        cfg(0, 5, 1'b0, 1'b1, 1'b0, 0);
        step(); step();
        enable = 1'b0;
        for (int k = 0; k < 7; k++) begin
            step();
            chk("dis_no_tick", 32'(tick), 32'd0);
        end
        enable = 1'b1;
        step(); step();
        chk("reen_early", 32'(tick[0]), 32'd0);
        step();
        chk("reen_tick", 32'(tick[0]), 32'd1);

        // ch2 rewritten on its terminal-count edge
        cfg(2, 6, 1'b0, 1'b1, 1'b0, 0);
        for (int k = 0; k < 5; k++) step();
        cfg(2, 2, 1'b0, 1'b1, 1'b0, 0);
        chk("wr_over_tc", 32'(tick[2]), 32'd0);
        step(); step();
        chk("ch2_p2_a", 32'(tick[2]), 32'd1);
        step(); step();
        chk("ch2_p2_b", 32'(tick[2]), 32'd1);

        // period 0 idles, out-of-range channel ignored, saturation, period 1
        cfg(3, 0, 1'b0, 1'b1, 1'b0, 0);
        for (int k = 0; k < 50; k++) begin
            step();
            chk("p0_idle", 32'(tick[3]), 32'd0);
        end
        cfg(NUM_CH, 1, 1'b1, 1'b1, 1'b1, 0);
        cfg(4, MAX_P + 5, 1'b0, 1'b1, 1'b0, 0);
        for (int k = 1; k <= 40; k++) begin
            step();
            chk("sat_spacing", 32'(tick[4]), (k % MAX_P == 0) ? 32'd1 : 32'd0);
        end
        cfg(3, 1, 1'b0, 1'b1, 1'b0, 0);
        for (int k = 0; k < 3; k++) begin
            step();
            chk("p1_every", 32'(tick[3]), 32'd1);
        end

        // reset mid-count
        reset = 1'b1;
        step();
        chk("rst_mid_tick", 32'(tick), 32'd0);
        chk("rst_mid_busy", 32'(busy), 32'h1f);
        reset = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            step();
            chk("rst_default", 32'(tick[0]), (k == 10) ? 32'd1 : 32'd0);
        end

`ifdef TICK_PHASE_EN
        cfg(1, 8, 1'b0, 1'b1, 1'b0, 6);
        step(); step();
        chk("phase_first", 32'(tick[1]), 32'd1);
        for (int k = 1; k <= 8; k++) begin
            step();
            chk("phase_period", 32'(tick[1]), (k == 8) ? 32'd1 : 32'd0);
        end
`endif

        // randomized traffic
        for (int n = 0; n < 1500; n++) begin
            reset      = ($urandom_range(0, 299) == 0);
            enable     = ($urandom_range(0, 9) != 0);
            ch_en      = ($urandom_range(0, 1) == 0) ? '1 : NUM_CH'($urandom);
            cfg_we     = ($urandom_range(0, 9) == 0);
            cfg_start  = ($urandom_range(0, 9) == 0);
            cfg_ch     = CH_W'($urandom_range(0, NUM_CH));
            cfg_period = CNT_W'($urandom_range(0, 25));
            cfg_mode   = 1'($urandom);
            cfg_phase  = CNT_W'($urandom_range(0, 25));
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
